// File: rtl/cache_control.sv
// Two-way set-associative cache controller: IDLE/COMPARE/WRITEBACK/ALLOCATE with write-back, write-allocate policy.
// Latency: hit responds 1 cycle after the request is seen in IDLE; a miss holds pmem_read/pmem_write until pmem_resp.
// Backpressure: CPU holds mem_read/mem_write until mem_resp; optional counters enabled by CACHE_PERF_CTR_EN.
module cache_control #(
    parameter int CNT_WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_read,
    input  logic       mem_write,
    input  logic [1:0] hit,
    input  logic [1:0] valid,
    input  logic [1:0] dirty,
    input  logic       lru,
    input  logic       pmem_resp,
    output logic       mem_resp,
    output logic       pmem_read,
    output logic       pmem_write,
    output logic       wb_addr_sel,
    output logic [1:0] load_data,
    output logic [1:0] load_tag,
    output logic [1:0] load_valid,
    output logic [1:0] load_dirty,
    output logic       data_src,
    output logic       dirty_in,
    output logic       load_lru,
    output logic       lru_in
`ifdef CACHE_PERF_CTR_EN
    ,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
`endif
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   refill_q, refill_d;

    logic [1:0] lru_oh;
    logic [1:0] hit_eff;
    logic       is_hit;
    logic       hit_way;
    logic [1:0] hit_oh;
    logic       victim_dirty;

    // The COMPARE right after a refill is always a hit on the refilled (lru) way.
    always_comb begin
        lru_oh       = lru ? 2'b10 : 2'b01;
        hit_eff      = (refill_q && (hit == 2'b00)) ? lru_oh : hit;
        is_hit       = |hit_eff;
        hit_way      = ~hit_eff[0];
        hit_oh       = hit_way ? 2'b10 : 2'b01;
        victim_dirty = valid[lru] & dirty[lru];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            refill_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            refill_q <= refill_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        refill_d = refill_q;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) state_d = COMPARE;
            end
            COMPARE: begin
                refill_d = 1'b0;
                if (is_hit)            state_d = IDLE;
                else if (victim_dirty) state_d = WRITEBACK;
                else                   state_d = ALLOCATE;
            end
            WRITEBACK: begin
                if (pmem_resp) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                if (pmem_resp) begin
                    state_d  = COMPARE;
                    refill_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_resp    = 1'b0;
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        wb_addr_sel = 1'b0;
        load_data   = 2'b00;
        load_tag    = 2'b00;
        load_valid  = 2'b00;
        load_dirty  = 2'b00;
        data_src    = 1'b0;
        dirty_in    = 1'b0;
        load_lru    = 1'b0;
        lru_in      = 1'b0;
        case (state_q)
            COMPARE: begin
                if (is_hit) begin
                    mem_resp = 1'b1;
                    load_lru = 1'b1;
                    lru_in   = ~hit_way;
                    // A simultaneous read+write is handled as a write.
                    if (mem_write) begin
                        load_data  = hit_oh;
                        load_dirty = hit_oh;
                        dirty_in   = 1'b1;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write  = 1'b1;
                wb_addr_sel = 1'b1;
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    load_data  = lru_oh;
                    load_tag   = lru_oh;
                    load_valid = lru_oh;
                    load_dirty = lru_oh;
                    data_src   = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef CACHE_PERF_CTR_EN
    logic [CNT_WIDTH-1:0] hit_count_q, hit_count_d;
    logic [CNT_WIDTH-1:0] miss_count_q, miss_count_d;

    // Post-refill hits are not counted: that access was already counted as a miss.
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (state_q == COMPARE) begin
            if (is_hit && !refill_q && (hit_count_q != {CNT_WIDTH{1'b1}}))
                hit_count_d = hit_count_q + CNT_WIDTH'(1);
            if (!is_hit && (miss_count_q != {CNT_WIDTH{1'b1}}))
                miss_count_d = miss_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_control.sv
// Directed self-checking bench for cache_control; inputs change and outputs are sampled on the falling edge.
module tb_cache_control;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_read, mem_write;
    logic [1:0] hit, valid, dirty;
    logic       lru, pmem_resp;
    logic       mem_resp, pmem_read, pmem_write, wb_addr_sel;
    logic [1:0] load_data, load_tag, load_valid, load_dirty;
    logic       data_src, dirty_in, load_lru, lru_in;
`ifdef CACHE_PERF_CTR_EN
    logic [31:0] hit_count, miss_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] outs;
    assign outs = {mem_resp, pmem_read, pmem_write, wb_addr_sel, load_data, load_tag,
                   load_valid, load_dirty, data_src, dirty_in, load_lru, lru_in};

    always #5 clk = ~clk;

    cache_control #(.CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .hit(hit), .valid(valid), .dirty(dirty), .lru(lru), .pmem_resp(pmem_resp),
        .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .wb_addr_sel(wb_addr_sel), .load_data(load_data), .load_tag(load_tag),
        .load_valid(load_valid), .load_dirty(load_dirty), .data_src(data_src),
        .dirty_in(dirty_in), .load_lru(load_lru), .lru_in(lru_in)
`ifdef CACHE_PERF_CTR_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_req();
        mem_read = 1'b0; mem_write = 1'b0; hit = 2'b00; pmem_resp = 1'b0;
    endtask

    // One hit access: IDLE cycle, then COMPARE cycle checked against the given expectations.
    task automatic hit_access(input string tag, input logic rd, input logic wr, input logic [1:0] h,
                              input logic [1:0] exp_ld, input logic exp_lru_in);
        @(negedge clk); mem_read = rd; mem_write = wr; hit = h; #1;
        chk({tag, "_idle_resp"}, mem_resp, 0);
        @(negedge clk); #1;
        chk({tag, "_resp"},     mem_resp, 1);
        chk({tag, "_load_lru"}, load_lru, 1);
        chk({tag, "_lru_in"},   lru_in, exp_lru_in);
        chk({tag, "_pmem"},     {pmem_read, pmem_write}, 0);
        chk({tag, "_ld_data"},  load_data, exp_ld);
        chk({tag, "_ld_dirty"}, load_dirty, exp_ld);
        chk({tag, "_dsrc_din"}, {data_src, dirty_in}, {1'b0, wr});
        @(negedge clk); clr_req(); #1;
        chk({tag, "_back_idle"}, outs, 0);
    endtask

    initial begin
        rst = 1'b0; clr_req(); valid = 2'b00; dirty = 2'b00; lru = 1'b0;
        #2;
        chk("reset_outs", outs, 0);
`ifdef CACHE_PERF_CTR_EN
        chk("reset_cnt", {hit_count[15:0], miss_count[15:0]}, 0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b1;

        hit_access("rd_hit01", 1'b1, 1'b0, 2'b01, 2'b00, 1'b1);
        hit_access("wr_hit10", 1'b0, 1'b1, 2'b10, 2'b10, 1'b0);
        hit_access("rw_hit11", 1'b1, 1'b1, 2'b11, 2'b01, 1'b1);

        // Dirty miss: writeback then refill of way 1.
        @(negedge clk); mem_read = 1'b1; lru = 1'b1; valid = 2'b10; dirty = 2'b10; #1;
        @(negedge clk); #1;
        chk("dm_cmp_resp", mem_resp, 0);
        chk("dm_cmp_pmem", {pmem_read, pmem_write}, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); pmem_resp = (i == 4); #1;
            chk("dm_wb_sig", {pmem_write, wb_addr_sel, pmem_read, mem_resp}, 4'b1100);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); pmem_resp = (i == 4); hit = (i == 4) ? 2'b10 : 2'b00; #1;
            chk("dm_al_sig", {pmem_read, wb_addr_sel, pmem_write, mem_resp}, 4'b1000);
            if (i == 4)
                chk("dm_al_load", {load_data, load_tag, load_valid, load_dirty, data_src, dirty_in},
                    {2'b10, 2'b10, 2'b10, 2'b10, 1'b1, 1'b0});
            else
                chk("dm_al_noload", {load_tag, load_valid}, 0);
        end
        @(negedge clk); pmem_resp = 1'b0; #1;
        chk("dm_final_resp", {mem_resp, load_lru, lru_in, pmem_read}, 4'b1100);
        @(negedge clk); clr_req(); #1;
        chk("dm_back_idle", outs, 0);

        // pmem_resp in IDLE is ignored.
        @(negedge clk); pmem_resp = 1'b1; #1;
        chk("idle_presp_a", outs, 0);
        @(negedge clk); pmem_resp = 1'b0; #1;
        chk("idle_presp_b", outs, 0);

        // Clean miss on way 0, with a stray pmem_resp during COMPARE.
        @(negedge clk); mem_read = 1'b1; lru = 1'b0; valid = 2'b01; dirty = 2'b00; #1;
        @(negedge clk); pmem_resp = 1'b1; #1;
        chk("cm_cmp_resp", mem_resp, 0);
        @(negedge clk); pmem_resp = 1'b0; #1;
        chk("cm_alloc", {pmem_read, pmem_write, wb_addr_sel}, 3'b100);
        @(negedge clk); pmem_resp = 1'b1; hit = 2'b01; #1;
        chk("cm_load", {load_data, load_tag, load_valid, load_dirty, data_src},
            {2'b01, 2'b01, 2'b01, 2'b01, 1'b1});
        @(negedge clk); pmem_resp = 1'b0; #1;
        chk("cm_final_resp", {mem_resp, lru_in}, 2'b11);
        @(negedge clk); clr_req(); #1;
        chk("cm_back_idle", outs, 0);
`ifdef CACHE_PERF_CTR_EN
        chk("cnt_hits", hit_count, 3);
        chk("cnt_misses", miss_count, 2);
`endif

        // Reset three cycles into ALLOCATE.
        @(negedge clk); mem_read = 1'b1; lru = 1'b0; valid = 2'b00; dirty = 2'b00; #1;
        @(negedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("ra_alloc", pmem_read, 1);
        end
        rst = 1'b0; #1;
        chk("ra_pmem_read_drop", pmem_read, 0);
        clr_req();
        @(negedge clk); rst = 1'b1; #1;
        chk("ra_after_rel", outs, 0);
        @(negedge clk); #1;
        chk("ra_stays_idle", outs, 0);

        // Reset mid-WRITEBACK.
        @(negedge clk); mem_write = 1'b1; lru = 1'b1; valid = 2'b10; dirty = 2'b10; #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("rw_wb", pmem_write, 1);
        rst = 1'b0; #1;
        chk("rw_pmem_write_drop", outs, 0);
        clr_req();
        @(negedge clk); rst = 1'b1; #1;
        chk("rw_after_rel", outs, 0);
`ifdef CACHE_PERF_CTR_EN
        chk("rw_cnt_cleared", {hit_count[15:0], miss_count[15:0]}, 0);
`endif

        hit_access("post_rst_hit", 1'b1, 1'b0, 2'b10, 2'b00, 1'b0);
`ifdef CACHE_PERF_CTR_EN
        chk("post_rst_cnt", {hit_count[15:0], miss_count[15:0]}, {16'd1, 16'd0});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
